psum_accumulator: RTL and testbench

- Sits directly downstream of the adder stage in the systolic-array datapath; consumes each registered sum (result_out/done) and accumulates K consecutive sums into one dot-product element.
- Completed elements are queued in a 2-entry first-word-fall-through output buffer with a valid/ready handshake toward the result collector.
- Provides in_ready so the array controller can gate doa when the buffer cannot absorb a finished element.

---
 rtl/psum_accumulator.sv | 147 ++++++++++++++
 tb/tb_psum_accumulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Accumulates K consecutive adder sums into one dot-product element and queues
// finished elements in a 2-entry first-word-fall-through buffer with valid/ready.
module psum_accumulator #(
   parameter int IN_W  = 17,
   parameter int K     = 4,
   parameter int ACC_W = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IN_W-1:0]      sum_in,
   input  logic                 sum_valid,
   input  logic                 clear,
   output logic                 in_ready,
   output logic [ACC_W-1:0]     out_data,
   output logic                 out_ovf,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(K):0]   term_cnt,
   output logic                 drop_err
);

   localparam int CNT_W = $clog2(K) + 1;
   localparam int SUM_W = ACC_W + 1;
   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(K - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
   logic             drop_err_q, drop_err_d;

   logic [ACC_W-1:0] mem_data_q [2];
   logic [ACC_W-1:0] mem_data_d [2];
   logic             mem_ovf_q  [2];
   logic             mem_ovf_d  [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [ACC_W-1:0] last_data_q, last_data_d;
   logic             last_ovf_q, last_ovf_d;

   logic [SUM_W-1:0] sum_ext;
   logic             accept;
   logic             last_term;
   logic             push;
   logic             pop;

   // in_ready depends only on registered occupancy, so a full buffer refuses
   // terms for the whole cycle even when the head is being popped.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign accept    = sum_valid && in_ready && !clear;
   assign last_term = (term_cnt_q == LAST_TERM);
   assign push      = accept && last_term;
   assign pop       = out_valid && out_ready;
   assign sum_ext   = {1'b0, acc_q} + SUM_W'(sum_in);

   always_comb begin
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      term_cnt_d = term_cnt_q;
      drop_err_d = drop_err_q;

      if (clear) begin
         acc_d      = '0;
         ovf_d      = 1'b0;
         term_cnt_d = '0;
      end else if (accept) begin
         if (last_term) begin
            acc_d      = '0;
            ovf_d      = 1'b0;
            term_cnt_d = '0;
         end else begin
            acc_d      = sum_ext[ACC_W-1:0];
            ovf_d      = ovf_q | sum_ext[ACC_W];
            term_cnt_d = term_cnt_q + CNT_W'(1);
         end
      end else if (sum_valid) begin
         drop_err_d = 1'b1;
      end
   end

   // Empty buffer keeps presenting the most recently popped element.
   always_comb begin
      mem_data_d  = mem_data_q;
      mem_ovf_d   = mem_ovf_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      last_data_d = last_data_q;
      last_ovf_d  = last_ovf_q;
      count_d     = count_q;

      if (push) begin
         mem_data_d[wr_ptr_q] = sum_ext[ACC_W-1:0];
         mem_ovf_d[wr_ptr_q]  = ovf_q | sum_ext[ACC_W];
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
         last_data_d = mem_data_q[rd_ptr_q];
         last_ovf_d  = mem_ovf_q[rd_ptr_q];
         rd_ptr_d    = ~rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q         <= '0;
         ovf_q         <= 1'b0;
         term_cnt_q    <= '0;
         drop_err_q    <= 1'b0;
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         mem_ovf_q[0]  <= 1'b0;
         mem_ovf_q[1]  <= 1'b0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         last_data_q   <= '0;
         last_ovf_q    <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         ovf_q         <= ovf_d;
         term_cnt_q    <= term_cnt_d;
         drop_err_q    <= drop_err_d;
         mem_data_q[0] <= mem_data_d[0];
         mem_data_q[1] <= mem_data_d[1];
         mem_ovf_q[0]  <= mem_ovf_d[0];
         mem_ovf_q[1]  <= mem_ovf_d[1];
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         last_data_q   <= last_data_d;
         last_ovf_q    <= last_ovf_d;
      end
   end

   assign out_data = out_valid ? mem_data_q[rd_ptr_q] : last_data_q;
   assign out_ovf  = out_valid ? mem_ovf_q[rd_ptr_q]  : last_ovf_q;
   assign term_cnt = term_cnt_q;
   assign drop_err = drop_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: a wide instance (ACC_W=19) for the main
// behaviour and a narrow one (ACC_W=17) that only sees the wrap-around vectors.
module tb_psum_accumulator;

   localparam int IN_W    = 17;
   localparam int K       = 4;
   localparam int ACC_W   = 19;
   localparam int ACC_W_B = 17;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [IN_W-1:0]     sum_in = '0;
   logic                sum_valid = 1'b0;
   logic                clear = 1'b0;
   logic                out_ready = 1'b1;
   logic                in_ready;
   logic [ACC_W-1:0]    out_data;
   logic                out_ovf;
   logic                out_valid;
   logic [$clog2(K):0]  term_cnt;
   logic                drop_err;

   logic                drive_b = 1'b0;
   logic                sum_valid_b;
   logic                out_ready_b = 1'b1;
   logic                in_ready_b;
   logic [ACC_W_B-1:0]  out_data_b;
   logic                out_ovf_b;
   logic                out_valid_b;
   logic [$clog2(K):0]  term_cnt_b;
   logic                drop_err_b;

   int checks = 0;
   int failures = 0;

   logic [ACC_W:0]   exp_q   [$];
   logic [ACC_W_B:0] exp_b_q [$];
   logic [ACC_W:0]   mon_exp;
   logic [ACC_W_B:0] mon_exp_b;

   assign sum_valid_b = sum_valid && drive_b;

   always #5 clk = ~clk;

   psum_accumulator #(.IN_W(IN_W), .K(K), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid),
      .clear(clear), .in_ready(in_ready), .out_data(out_data), .out_ovf(out_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .term_cnt(term_cnt),
      .drop_err(drop_err)
   );

   psum_accumulator #(.IN_W(IN_W), .K(K), .ACC_W(ACC_W_B)) dut_b (
      .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid_b),
      .clear(clear), .in_ready(in_ready_b), .out_data(out_data_b), .out_ovf(out_ovf_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .term_cnt(term_cnt_b),
      .drop_err(drop_err_b)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // One cycle of input; returns 1 time unit after the sampling edge.
   task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d, input logic c);
      sum_valid = v;
      sum_in    = d;
      clear     = c;
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [ACC_W-1:0] data, input logic ovf);
      exp_q.push_back({ovf, data});
   endtask

   task automatic doReset();
      reset     = 1'b0;
      sum_valid = 1'b0;
      clear     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Monitor: every handshake on either instance pops the scoreboard.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_output actual=0x%0h required=none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("out_data", 32'(out_data), 32'(mon_exp[ACC_W-1:0]));
            checkOutput("out_ovf", 32'(out_ovf), 32'(mon_exp[ACC_W]));
         end
      end
      if (reset && out_valid_b && out_ready_b) begin
         if (exp_b_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_output_b actual=0x%0h required=none", out_data_b);
         end else begin
            mon_exp_b = exp_b_q.pop_front();
            checkOutput("out_data_b", 32'(out_data_b), 32'(mon_exp_b[ACC_W_B-1:0]));
            checkOutput("out_ovf_b", 32'(out_ovf_b), 32'(mon_exp_b[ACC_W_B]));
         end
      end
   end

   initial begin
      doReset();
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_data", 32'(out_data), 32'd0);
      checkOutput("reset_out_ovf", 32'(out_ovf), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_term_cnt", 32'(term_cnt), 32'd0);
      checkOutput("reset_drop_err", 32'(drop_err), 32'd0);
      checkOutput("reset_in_ready_b", 32'(in_ready_b), 32'd1);

      // 10+20+30+40 = 100, term_cnt 0,1,2,3,0
      pushExp(19'd100, 1'b0);
      applyStimulus(1'b1, 17'd10, 1'b0);
      checkOutput("t1_term_cnt1", 32'(term_cnt), 32'd1);
      applyStimulus(1'b1, 17'd20, 1'b0);
      checkOutput("t1_term_cnt2", 32'(term_cnt), 32'd2);
      applyStimulus(1'b1, 17'd30, 1'b0);
      checkOutput("t1_term_cnt3", 32'(term_cnt), 32'd3);
      checkOutput("t1_valid_early", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 17'd40, 1'b0);
      checkOutput("t1_term_cnt0", 32'(term_cnt), 32'd0);
      checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 17'd0, 1'b0);
      checkOutput("t1_drained", 32'(out_valid), 32'd0);

      // 4 x 0x1FFFF: 0x7FFFC no wrap at 19 bits, 0x1FFFC wrapped at 17 bits
      pushExp(19'h7FFFC, 1'b0);
      exp_b_q.push_back({1'b1, 17'h1FFFC});
      drive_b = 1'b1;
      repeat (4) applyStimulus(1'b1, 17'h1FFFF, 1'b0);
      applyStimulus(1'b0, 17'd0, 1'b0);
      drive_b = 1'b0;
      applyStimulus(1'b0, 17'd0, 1'b0);

      // Fill buffer with 4 and 8, third element's first term is dropped
      out_ready = 1'b0;
      pushExp(19'd4, 1'b0);
      pushExp(19'd8, 1'b0);
      repeat (4) applyStimulus(1'b1, 17'd1, 1'b0);
      checkOutput("t3_in_ready_one", 32'(in_ready), 32'd1);
      repeat (4) applyStimulus(1'b1, 17'd2, 1'b0);
      checkOutput("t3_in_ready_full", 32'(in_ready), 32'd0);
      checkOutput("t3_head_held", 32'(out_data), 32'd4);
      applyStimulus(1'b1, 17'd3, 1'b0);
      checkOutput("t3_drop_err", 32'(drop_err), 32'd1);
      checkOutput("t3_term_cnt", 32'(term_cnt), 32'd0);
      out_ready = 1'b1;
      applyStimulus(1'b0, 17'd0, 1'b0);
      applyStimulus(1'b0, 17'd0, 1'b0);
      checkOutput("t3_empty", 32'(out_valid), 32'd0);
      checkOutput("t3_in_ready_back", 32'(in_ready), 32'd1);
      checkOutput("t3_last_popped", 32'(out_data), 32'd8);

      // Clear with a simultaneous term, then 1,1,1,1 gives 4
      doReset();
      pushExp(19'd4, 1'b0);
      applyStimulus(1'b1, 17'd5, 1'b0);
      applyStimulus(1'b1, 17'd6, 1'b0);
      checkOutput("t4_term_cnt2", 32'(term_cnt), 32'd2);
      applyStimulus(1'b1, 17'd7, 1'b1);
      checkOutput("t4_clear_cnt", 32'(term_cnt), 32'd0);
      repeat (4) applyStimulus(1'b1, 17'd1, 1'b0);
      applyStimulus(1'b0, 17'd0, 1'b0);
      checkOutput("t4_drop_err", 32'(drop_err), 32'd0);

      // Full buffer with out_ready=1: term refused that cycle, accepted next
      out_ready = 1'b0;
      pushExp(19'd4, 1'b0);
      pushExp(19'd8, 1'b0);
      pushExp(19'd20, 1'b0);
      repeat (4) applyStimulus(1'b1, 17'd1, 1'b0);
      repeat (4) applyStimulus(1'b1, 17'd2, 1'b0);
      out_ready = 1'b1;
      checkOutput("t5_in_ready_full", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 17'd5, 1'b0);
      checkOutput("t5_refused_cnt", 32'(term_cnt), 32'd0);
      checkOutput("t5_in_ready_next", 32'(in_ready), 32'd1);
      checkOutput("t5_drop_err", 32'(drop_err), 32'd1);
      applyStimulus(1'b1, 17'd5, 1'b0);
      checkOutput("t5_accepted_cnt", 32'(term_cnt), 32'd1);
      repeat (3) applyStimulus(1'b1, 17'd5, 1'b0);
      repeat (3) applyStimulus(1'b0, 17'd0, 1'b0);

      // Reset mid-accumulation with one buffered element discards everything
      doReset();
      out_ready = 1'b0;
      repeat (4) applyStimulus(1'b1, 17'd1, 1'b0);
      repeat (2) applyStimulus(1'b1, 17'd1, 1'b0);
      sum_valid = 1'b0;
      checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
      checkOutput("t6_pre_cnt", 32'(term_cnt), 32'd2);
      #1 reset = 1'b0;
      #1;
      checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
      checkOutput("t6_async_cnt", 32'(term_cnt), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      out_ready = 1'b1;
      pushExp(19'd4, 1'b0);
      repeat (4) applyStimulus(1'b1, 17'd1, 1'b0);
      repeat (3) applyStimulus(1'b0, 17'd0, 1'b0);

      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      checkOutput("scoreboard_b_empty", 32'(exp_b_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
